pipeline_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage 64-bit pipeline. It detects load-use hazards in ID and taken branches resolved in MEM, and holds the pipeline while data memory is busy. It also runs a debug halt/drain handshake and keeps saturating stall and flush performance counters. It drives the enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/pipeline_hazard_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, memory wait,
// debug halt/drain, plus saturating stall and flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_mem_read,
    input  logic                  mem_branch,
    input  logic                  mem_zero,
    input  logic                  mem_mem_read,
    input  logic                  mem_mem_write,
    input  logic                  dmem_ready,
    input  logic                  halt_req,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_write,
    output logic                  ex_mem_flush,
    output logic                  halt_ack,
    output logic                  timeout_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [1:0]            dbg_state_o
);

    localparam int WAIT_W  = $clog2(TIMEOUT + 2);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic               halt_ack_q, halt_ack_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               stall_inc, flush_inc;

    logic pc_write_c, pc_src_c, if_id_write_c, if_id_flush_c;
    logic id_ex_write_c, id_ex_flush_c, ex_mem_write_c, ex_mem_flush_c;

    logic mem_busy, br_taken, load_use;

    assign mem_busy = (mem_mem_read | mem_mem_write) & ~dmem_ready;
    assign br_taken = mem_branch & mem_zero;
    assign load_use = id_ex_mem_read & (id_ex_rd != '0) &
                      ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        timeout_err_d  = timeout_err_q;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        pc_write_c     = 1'b1;
        pc_src_c       = 1'b0;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_write_c  = 1'b1;
        id_ex_flush_c  = 1'b0;
        ex_mem_write_c = 1'b1;
        ex_mem_flush_c = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    pc_write_c     = 1'b0;
                    if_id_write_c  = 1'b0;
                    id_ex_write_c  = 1'b0;
                    ex_mem_write_c = 1'b0;
                    stall_inc      = 1'b1;
                    wait_cnt_d     = WAIT_W'(1);
                    state_d        = MEM_WAIT;
                end else if (br_taken) begin
                    // A coincident load-use hazard is moot: its instruction is flushed here.
                    pc_src_c       = 1'b1;
                    if_id_flush_c  = 1'b1;
                    id_ex_flush_c  = 1'b1;
                    ex_mem_flush_c = 1'b1;
                    flush_inc      = 1'b1;
                end else if (load_use) begin
                    pc_write_c     = 1'b0;
                    if_id_write_c  = 1'b0;
                    id_ex_flush_c  = 1'b1;
                    stall_inc      = 1'b1;
                end else if (halt_req) begin
                    drain_cnt_d    = DRAIN_W'(DRAIN_CYCLES);
                    state_d        = DRAIN;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    wait_cnt_d     = '0;
                    state_d        = RUN;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
                    timeout_err_d  = 1'b1;
                    wait_cnt_d     = '0;
                    state_d        = RUN;
                end else begin
                    pc_write_c     = 1'b0;
                    if_id_write_c  = 1'b0;
                    id_ex_write_c  = 1'b0;
                    ex_mem_write_c = 1'b0;
                    stall_inc      = 1'b1;
                    wait_cnt_d     = wait_cnt_q + WAIT_W'(1);
                end
            end
            DRAIN: begin
                // Bubbles enter at IF/ID while the older instructions retire downstream.
                pc_write_c    = 1'b0;
                if_id_flush_c = 1'b1;
                if (mem_busy) begin
                    if_id_flush_c  = 1'b0;
                    if_id_write_c  = 1'b0;
                    id_ex_write_c  = 1'b0;
                    ex_mem_write_c = 1'b0;
                    stall_inc      = 1'b1;
                end else begin
                    if (br_taken) begin
                        pc_write_c     = 1'b1;
                        pc_src_c       = 1'b1;
                        id_ex_flush_c  = 1'b1;
                        ex_mem_flush_c = 1'b1;
                        flush_inc      = 1'b1;
                    end
                    if (drain_cnt_q <= DRAIN_W'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                    end
                end
                if (!halt_req) begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                id_ex_write_c  = 1'b0;
                ex_mem_write_c = 1'b0;
                if (!halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign halt_ack_d  = (state_d == HALTED);
    assign stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            halt_ack_q    <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            timeout_err_q <= timeout_err_d;
            halt_ack_q    <= halt_ack_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // Pipeline controls are held low for as long as reset is asserted.
    assign pc_write     = rst & pc_write_c;
    assign pc_src       = rst & pc_src_c;
    assign if_id_write  = rst & if_id_write_c;
    assign if_id_flush  = rst & if_id_flush_c;
    assign id_ex_write  = rst & id_ex_write_c;
    assign id_ex_flush  = rst & id_ex_flush_c;
    assign ex_mem_write = rst & ex_mem_write_c;
    assign ex_mem_flush = rst & ex_mem_flush_c;

    assign halt_ack    = halt_ack_q;
    assign timeout_err = timeout_err_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign dbg_state_o = state_q;

endmodule
